// File: rtl/watch_ctrl.sv
// watch_ctrl: run/stop/set control FSM with a tick prescaler and set-value registers.
// Define WATCH_CTRL_BLINK_EN to blink the edited field from a divided clock.
module watch_ctrl #(
   parameter int CLK_HZ  = 100000000,
   parameter int TICK_HZ = 1000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_run,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_clear,
   output logic       o_tick,
   output logic       o_clear,
   output logic       o_load,
   output logic [4:0] o_set_hour,
   output logic [5:0] o_set_min,
   output logic [1:0] o_state,
   output logic       o_blink
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      STOP     = 2'd0,
      RUN      = 2'd1,
      SET_HOUR = 2'd2,
      SET_MIN  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] presc;
   logic          act_clear;
   logic          act_run;
   logic          act_mode;
   logic          act_up;
   logic          clear_nx;
   logic          load_nx;
   logic          in_set;

   // Only the highest-priority button is allowed to act
   assign act_clear = i_btn_clear;
   assign act_run   = i_btn_run & ~i_btn_clear;
   assign act_mode  = i_btn_mode & ~i_btn_run & ~i_btn_clear;
   assign act_up    = i_btn_up & ~i_btn_mode & ~i_btn_run & ~i_btn_clear;

   assign in_set = (state == SET_HOUR) || (state == SET_MIN);

   always_comb begin
      state_nx = state;
      clear_nx = 1'b0;
      load_nx  = 1'b0;
      unique case (state)
         STOP: begin
            if (act_clear)     clear_nx = 1'b1;
            else if (act_run)  state_nx = RUN;
            else if (act_mode) state_nx = SET_HOUR;
         end
         RUN: begin
            if (act_clear)    clear_nx = 1'b1;
            else if (act_run) state_nx = STOP;
         end
         SET_HOUR: begin
            if (act_mode) state_nx = SET_MIN;
         end
         SET_MIN: begin
            if (act_mode) begin
               state_nx = STOP;
               load_nx  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state      <= STOP;
         presc      <= '0;
         o_clear    <= 1'b0;
         o_load     <= 1'b0;
         o_set_hour <= '0;
         o_set_min  <= '0;
      end else begin
         state   <= state_nx;
         o_clear <= clear_nx;
         o_load  <= load_nx;
         // Held outside RUN so a resumed run keeps its tick phase
         if (clear_nx) begin
            presc <= '0;
         end else if (state == RUN) begin
            if (presc == PW'(DIV - 1)) presc <= '0;
            else                       presc <= presc + 1'b1;
         end
         if (state == SET_HOUR) begin
            if (act_clear)
               o_set_hour <= '0;
            else if (act_up)
               o_set_hour <= (o_set_hour == 5'd23) ? 5'd0 : o_set_hour + 5'd1;
         end
         if (state == SET_MIN) begin
            if (act_clear)
               o_set_min <= '0;
            else if (act_up)
               o_set_min <= (o_set_min == 6'd59) ? 6'd0 : o_set_min + 6'd1;
         end
      end
   end

   assign o_tick  = (state == RUN) && (presc == PW'(DIV - 1));
   assign o_state = state;

`ifdef WATCH_CTRL_BLINK_EN
   localparam int BDIV = DIV * 500;
   localparam int BW   = $clog2(BDIV);

   logic [BW-1:0] bcnt;
   logic          blink;

   // Restart the blink phase whenever the edited field changes
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         bcnt  <= '0;
         blink <= 1'b0;
      end else if (!in_set || (state_nx != state)) begin
         bcnt  <= '0;
         blink <= 1'b0;
      end else if (bcnt == BW'(BDIV - 1)) begin
         bcnt  <= '0;
         blink <= ~blink;
      end else begin
         bcnt  <= bcnt + 1'b1;
      end
   end

   assign o_blink = blink;
`else
   assign o_blink = in_set;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// tb_watch_ctrl: directed vector table plus hand sequences for watch_ctrl.
// Runs with CLK_HZ=10, TICK_HZ=1 so one tick period is 10 clocks.
module tb_watch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       mode = 1'b0;
   logic       up = 1'b0;
   logic       clr = 1'b0;
   logic       tick;
   logic       clear_o;
   logic       load;
   logic [4:0] hour;
   logic [5:0] min;
   logic [1:0] st;
   logic       blink;

   int npass = 0;
   int ntotal = 0;

   watch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_btn_run   (run),
      .i_btn_mode  (mode),
      .i_btn_up    (up),
      .i_btn_clear (clr),
      .o_tick      (tick),
      .o_clear     (clear_o),
      .o_load      (load),
      .o_set_hour  (hour),
      .o_set_min   (min),
      .o_state     (st),
      .o_blink     (blink)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r, m, u, c;
      int st, hr, mn;
      int ck, ld, tk;
   } vec_t;

   vec_t vt [25];

   task automatic check(input string nm, input int act, input int exp);
      ntotal++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic step(input logic r, input logic m, input logic u, input logic c);
      run = r; mode = m; up = u; clr = c;
      @(posedge clk);
      #1;
      run = 1'b0; mode = 1'b0; up = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_blink;
      int first;
      int seen;

      vt = '{
         '{0,0,0,0, 0,0,0, 0,0,0},
         '{0,0,1,0, 0,0,0, 0,0,0},
         '{0,0,0,1, 0,0,0, 1,0,0},
         '{0,0,0,0, 0,0,0, 0,0,0},
         '{0,1,0,0, 2,0,0, 0,0,0},
         '{0,0,1,0, 2,1,0, 0,0,0},
         '{0,0,1,0, 2,2,0, 0,0,0},
         '{1,0,0,0, 2,2,0, 0,0,0},
         '{0,0,0,1, 2,0,0, 0,0,0},
         '{0,0,1,0, 2,1,0, 0,0,0},
         '{0,1,1,0, 3,1,0, 0,0,0},
         '{0,0,1,0, 3,1,1, 0,0,0},
         '{0,0,1,0, 3,1,2, 0,0,0},
         '{0,0,0,1, 3,1,0, 0,0,0},
         '{0,0,1,0, 3,1,1, 0,0,0},
         '{0,1,0,0, 0,1,1, 0,1,0},
         '{0,0,0,0, 0,1,1, 0,0,0},
         '{0,1,0,0, 2,1,1, 0,0,0},
         '{0,1,0,0, 3,1,1, 0,0,0},
         '{0,1,0,0, 0,1,1, 0,1,0},
         '{1,0,0,0, 1,1,1, 0,0,0},
         '{0,1,0,0, 1,1,1, 0,0,0},
         '{0,0,1,0, 1,1,1, 0,0,0},
         '{1,0,0,1, 1,1,1, 1,0,0},
         '{1,0,0,0, 0,1,1, 0,0,0}
      };

      // Reset state
      do_reset();
      check("rst_state", int'(st), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_clear", int'(clear_o), 0);
      check("rst_load", int'(load), 0);
      check("rst_hour", int'(hour), 0);
      check("rst_min", int'(min), 0);
      check("rst_blink", int'(blink), 0);

      // Vector table
      for (int i = 0; i < 25; i++) begin
         step(vt[i].r[0], vt[i].m[0], vt[i].u[0], vt[i].c[0]);
`ifdef WATCH_CTRL_BLINK_EN
         exp_blink = 0;
`else
         exp_blink = (vt[i].st >= 2) ? 1 : 0;
`endif
         check($sformatf("v%0d_state", i), int'(st), vt[i].st);
         check($sformatf("v%0d_hour", i), int'(hour), vt[i].hr);
         check($sformatf("v%0d_min", i), int'(min), vt[i].mn);
         check($sformatf("v%0d_clear", i), int'(clear_o), vt[i].ck);
         check($sformatf("v%0d_load", i), int'(load), vt[i].ld);
         check($sformatf("v%0d_tick", i), int'(tick), vt[i].tk);
         check($sformatf("v%0d_blink", i), int'(blink), exp_blink);
      end

      // Tick cadence from a fresh run
      do_reset();
      step(1, 0, 0, 0);
      check("run_state", int'(st), 1);
      check("run_tick_c1", int'(tick), 0);
      for (int c = 2; c <= 30; c++) begin
         step(0, 0, 0, 0);
         check($sformatf("run_tick_c%0d", c), int'(tick), (c % 10 == 0) ? 1 : 0);
      end

      // Stop at prescaler 4, hold, resume keeps phase
      do_reset();
      step(1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("stop_state", int'(st), 0);
      seen = int'(tick);
      for (int c = 0; c < 15; c++) begin
         step(0, 0, 0, 0);
         seen += int'(tick);
      end
      check("stop_no_tick", seen, 0);
      step(1, 0, 0, 0);
      check("resume_state", int'(st), 1);
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) step(0, 0, 0, 0);
         check($sformatf("resume_tick_c%0d", c), int'(tick),
               (c == 5 || c == 15) ? 1 : 0);
      end

      // Set with wraps and load
      do_reset();
      step(0, 1, 0, 0);
      repeat (25) step(0, 0, 1, 0);
      check("wrap_hour", int'(hour), 1);
      step(0, 1, 0, 0);
      repeat (61) step(0, 0, 1, 0);
      check("wrap_min", int'(min), 1);
      step(0, 1, 0, 0);
      check("load_pulse", int'(load), 1);
      check("load_state", int'(st), 0);
      check("load_hour", int'(hour), 1);
      check("load_min", int'(min), 1);
      step(0, 0, 0, 0);
      check("load_drop", int'(load), 0);
      check("keep_hour", int'(hour), 1);
      check("keep_min", int'(min), 1);

      // Clear beats run in RUN and restarts the prescaler
      do_reset();
      step(1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0);
      step(1, 0, 0, 1);
      check("crun_state", int'(st), 1);
      check("crun_clear", int'(clear_o), 1);
      check("crun_tick", int'(tick), 0);
      step(0, 0, 0, 0);
      check("crun_clear_drop", int'(clear_o), 0);
      first = 0;
      for (int c = 2; c <= 20; c++) begin
         if (c > 2) step(0, 0, 0, 0);
         if (tick && first == 0) first = c;
      end
      check("crun_first_tick", first, 10);

      // Reset mid-edit discards edit, no load
      do_reset();
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      repeat (30) step(0, 0, 1, 0);
      check("edit_min", int'(min), 30);
      check("edit_state", int'(st), 3);
      rst_n = 1'b0;
      mode = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mode = 1'b0;
      check("medit_min", int'(min), 0);
      check("medit_state", int'(st), 0);
      check("medit_load", int'(load), 0);
      step(0, 0, 0, 0);
      check("medit_load_after", int'(load), 0);
      check("medit_state_after", int'(st), 0);

      // Blink behaviour
      do_reset();
      step(0, 1, 0, 0);
`ifdef WATCH_CTRL_BLINK_EN
      for (int c = 1; c <= 10000; c++) begin
         step(0, 0, 0, 0);
         if (c == 4999)  check("blink_4999", int'(blink), 0);
         if (c == 5000)  check("blink_5000", int'(blink), 1);
         if (c == 9999)  check("blink_9999", int'(blink), 1);
         if (c == 10000) check("blink_10000", int'(blink), 0);
      end
      step(0, 1, 0, 0);
      check("blink_min_restart", int'(blink), 0);
`else
      check("blink_hour", int'(blink), 1);
      step(0, 1, 0, 0);
      check("blink_min", int'(blink), 1);
      step(0, 1, 0, 0);
      check("blink_stop", int'(blink), 0);
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
